// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory bus port between retired stores and the
//   execute-stage load unit. Retired stores are queued in a small circular
//   store buffer so retirement never waits on memory; loads are issued one
//   at a time, tracked by the tag memory hands back, and returned as a
//   one-cycle ld_data_valid pulse.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   st_valid/size/addr/data retiring store (push into the store buffer)
//   st_full                 buffer full, retire must hold stores
//   ld_req/size/addr        load request, held until ld_grant
//   ld_squash               discard the requested or in-flight load
//   ld_grant                load accepted by memory this cycle
//   ld_data_valid, ld_data  returned load data (one-cycle pulse)
//   mem_command/size/addr/data  bus command issued this cycle
//   mem_response            same-cycle acceptance tag (0 = rejected)
//   mem_tag, mem_rdata      returning load tag/data (tag 0 = nothing)
//   idle                    buffer empty and no load outstanding
module dmem_port_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SQ_DEPTH = 4,
  parameter int unsigned TAG_W    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [1:0]       st_size,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  output logic             st_full,
  input  logic             ld_req,
  input  logic [1:0]       ld_size,
  input  logic [XLEN-1:0]  ld_addr,
  input  logic             ld_squash,
  output logic             ld_grant,
  output logic             ld_data_valid,
  output logic [XLEN-1:0]  ld_data,
  output logic [1:0]       mem_command,
  output logic [1:0]       mem_size,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_data,
  input  logic [TAG_W-1:0] mem_response,
  input  logic [TAG_W-1:0] mem_tag,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             idle
);

  localparam int unsigned PTR_W = $clog2(SQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic [1:0] {
    L_IDLE,
    L_WAIT,
    L_DROP
  } ld_state_e;

  // Store buffer storage (not reset: validity is defined by head/count)
  logic [1:0]      sq_size_q [SQ_DEPTH];
  logic [XLEN-1:0] sq_addr_q [SQ_DEPTH];
  logic [XLEN-1:0] sq_data_q [SQ_DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  ld_state_e        state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             ld_valid_q, ld_valid_d;
  logic [XLEN-1:0]  ld_data_q, ld_data_d;

  logic             sq_full, sq_empty, hazard, load_go, store_go, accepted;
  logic             push, pop, tag_hit;
  logic [PTR_W-1:0] age;
  bus_cmd_e         cmd;

  assign sq_full       = (count_q == CNT_W'(SQ_DEPTH));
  assign sq_empty      = (count_q == '0);
  assign st_full       = sq_full;
  assign idle          = sq_empty && (state_q == L_IDLE);
  assign ld_data_valid = ld_valid_q;
  assign ld_data       = ld_data_q;
  assign mem_command   = cmd;
  assign accepted      = (mem_response != '0);
  assign tag_hit       = (tag_q != '0) && (mem_tag == tag_q);

  // Word-granular hazard: an entry is live when its distance from head is
  // below count, which keeps the check correct across pointer wrap.
  always_comb begin
    hazard = 1'b0;
    age    = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      age = PTR_W'(i) - head_q;
      if (({1'b0, age} < count_q) &&
          (sq_addr_q[PTR_W'(i)][XLEN-1:2] == ld_addr[XLEN-1:2]))
        hazard = 1'b1;
    end
  end

  // Arbitration: an eligible load beats the head store; a full buffer
  // always hands the port to stores.
  always_comb begin
    load_go  = ld_req && (state_q == L_IDLE) && !ld_squash && !hazard && !sq_full;
    store_go = !load_go && !sq_empty;
    cmd      = BUS_NONE;
    mem_size = '0;
    mem_addr = '0;
    mem_data = '0;
    if (load_go) begin
      cmd      = BUS_LOAD;
      mem_size = ld_size;
      mem_addr = ld_addr;
    end else if (store_go) begin
      cmd      = BUS_STORE;
      mem_size = sq_size_q[head_q];
      mem_addr = sq_addr_q[head_q];
      mem_data = sq_data_q[head_q];
    end
  end

  // Store buffer pointers and occupancy
  always_comb begin
    push    = st_valid && !sq_full;
    pop     = store_go && accepted;
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Load FSM
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data_q;
    ld_grant   = 1'b0;
    case (state_q)
      L_IDLE: begin
        if (load_go && accepted) begin
          ld_grant = 1'b1;
          tag_d    = mem_response;
          state_d  = L_WAIT;
        end
      end
      L_WAIT: begin
        // A squash coinciding with the return wins: data is dropped.
        if (tag_hit) begin
          state_d = L_IDLE;
          if (!ld_squash) begin
            ld_valid_d = 1'b1;
            ld_data_d  = mem_rdata;
          end
        end else if (ld_squash) begin
          state_d = L_DROP;
        end
      end
      L_DROP: begin
        if (tag_hit) state_d = L_IDLE;
      end
      default: state_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      state_q    <= L_IDLE;
      tag_q      <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      state_q    <= state_d;
      tag_q      <= tag_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      sq_size_q[tail_q] <= st_size;
      sq_addr_q[tail_q] <= st_addr;
      sq_data_q[tail_q] <= st_data;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus pushes the expected bus
// commands and load returns into queues; a monitor pops and compares
// whenever the DUT drives a bus command or an ld_data_valid pulse.
module tb_dmem_port_arbiter;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  logic        clock, reset;
  logic        st_valid, st_full;
  logic [1:0]  st_size;
  logic [31:0] st_addr, st_data;
  logic        ld_req, ld_squash, ld_grant, ld_data_valid;
  logic [1:0]  ld_size;
  logic [31:0] ld_addr, ld_data;
  logic [1:0]  mem_command, mem_size;
  logic [31:0] mem_addr, mem_data, mem_rdata;
  logic [3:0]  mem_response, mem_tag;
  logic        idle;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        grant;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] ld_q[$];
  int          checks = 0;
  int          failures = 0;

  // Memory model: rejects the next rej_left commands, then accepts with a
  // fixed store tag or the per-load tag chosen by the stimulus.
  int          rej_left = 0;
  int          rej_cfg = 0;
  logic        rej_set;
  logic [3:0]  load_tag;

  dmem_port_arbiter #(.XLEN(32), .SQ_DEPTH(4), .TAG_W(4)) dut (
    .clock(clock), .reset(reset),
    .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
    .st_full(st_full),
    .ld_req(ld_req), .ld_size(ld_size), .ld_addr(ld_addr), .ld_squash(ld_squash),
    .ld_grant(ld_grant), .ld_data_valid(ld_data_valid), .ld_data(ld_data),
    .mem_command(mem_command), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_response(mem_response), .mem_tag(mem_tag),
    .mem_rdata(mem_rdata), .idle(idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    if (mem_command == C_NONE || rej_left != 0) mem_response = 4'd0;
    else if (mem_command == C_LOAD)             mem_response = load_tag;
    else                                        mem_response = 4'd2;
  end

  always @(posedge clock) begin
    if (rej_set) rej_left <= rej_cfg;
    else if (mem_command != C_NONE && rej_left > 0) rej_left <= rej_left - 1;
  end

  always @(posedge clock) begin
    if (reset && st_valid && st_full) begin
      failures++;
      $display("FAIL st_valid_while_full: st_valid=1 with st_full=1, required no retire");
    end
  end

  // Monitor: samples 4 time units after the negedge, before the next posedge.
  always @(negedge clock) begin
    bus_t e;
    logic [31:0] ed;
    #4;
    if (mem_command != C_NONE) begin
      checks++;
      if (bus_q.size() == 0) begin
        failures++;
        $display("FAIL bus_unexpected: got cmd=%0d addr=%h, required no command", mem_command, mem_addr);
      end else begin
        e = bus_q.pop_front();
        if (mem_command !== e.cmd || mem_size !== e.size || mem_addr !== e.addr ||
            mem_data !== e.data || ld_grant !== e.grant) begin
          failures++;
          $display("FAIL bus_cmd: got cmd=%0d size=%0d addr=%h data=%h grant=%0b, required cmd=%0d size=%0d addr=%h data=%h grant=%0b",
                   mem_command, mem_size, mem_addr, mem_data, ld_grant,
                   e.cmd, e.size, e.addr, e.data, e.grant);
        end
      end
    end
    if (ld_data_valid) begin
      checks++;
      if (ld_q.size() == 0) begin
        failures++;
        $display("FAIL ld_unexpected: got ld_data_valid with ld_data=%h, required no pulse", ld_data);
      end else begin
        ed = ld_q.pop_front();
        if (ld_data !== ed) begin
          failures++;
          $display("FAIL ld_data: got %h, required %h", ld_data, ed);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic void exp_bus(input logic [1:0] c, input logic [1:0] s,
                                  input logic [31:0] a, input logic [31:0] d, input logic g);
    bus_t e;
    e.cmd = c; e.size = s; e.addr = a; e.data = d; e.grant = g;
    bus_q.push_back(e);
  endfunction

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
  endtask

  // Called right after driving at a negedge; n = cycles until ld_grant.
  task automatic wait_grant(output int n, output bit got);
    got = 1'b0; n = -1;
    for (int k = 0; k < 12; k++) begin
      #4;
      if (ld_grant) begin got = 1'b1; n = k; break; end
      @(negedge clock);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock); #4;
      if (idle) begin ok = 1'b1; break; end
    end
  endtask

  task automatic ret_data(input logic [3:0] t, input logic [31:0] d);
    @(negedge clock); mem_tag = t; mem_rdata = d;
    @(negedge clock); mem_tag = 4'd0;
  endtask

  initial begin
    int n;
    bit got, ok, saw_full;
    int i;
    reset = 1'b0; st_valid = 1'b0; st_size = 2'd0; st_addr = '0; st_data = '0;
    ld_req = 1'b0; ld_size = 2'd0; ld_addr = '0; ld_squash = 1'b0;
    mem_tag = 4'd0; mem_rdata = '0; rej_set = 1'b0; load_tag = 4'd0;
    #3;
    check("rst_st_full", {31'd0, st_full}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_mem_command", {30'd0, mem_command}, 32'd0);
    check("rst_ld_data_valid", {31'd0, ld_data_valid}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;

    // 1: four back-to-back stores, memory rejects the first three attempts
    //    so the buffer reaches full before anything drains.
    for (int k = 0; k < 4; k++) exp_bus(C_STORE, 2'd2, 32'h100, 32'hA000_0100, 1'b0);
    exp_bus(C_STORE, 2'd2, 32'h104, 32'hA000_0104, 1'b0);
    exp_bus(C_STORE, 2'd2, 32'h108, 32'hA000_0108, 1'b0);
    exp_bus(C_STORE, 2'd2, 32'h10C, 32'hA000_010C, 1'b0);
    @(negedge clock); rej_cfg = 3; rej_set = 1'b1; drive_st(32'h100, 32'hA000_0100, 2'd2);
    @(negedge clock); rej_set = 1'b0; drive_st(32'h104, 32'hA000_0104, 2'd2);
    @(negedge clock); drive_st(32'h108, 32'hA000_0108, 2'd2);
    @(negedge clock); drive_st(32'h10C, 32'hA000_010C, 2'd2);
    @(negedge clock); st_valid = 1'b0; #4;
    check("t1_st_full", {31'd0, st_full}, 32'd1);
    check("t1_not_idle", {31'd0, idle}, 32'd0);
    wait_idle(ok);
    check("t1_idle_after_drain", {31'd0, ok}, 32'd1);

    // 2: load wins over two buffered stores and returns data.
    exp_bus(C_STORE, 2'd2, 32'h200, 32'hB000_0200, 1'b0);
    exp_bus(C_LOAD, 2'd2, 32'h300, 32'h0, 1'b1);
    exp_bus(C_STORE, 2'd2, 32'h200, 32'hB000_0200, 1'b0);
    exp_bus(C_STORE, 2'd2, 32'h204, 32'hB000_0204, 1'b0);
    ld_q.push_back(32'hDEADBEEF);
    @(negedge clock); rej_cfg = 1; rej_set = 1'b1; drive_st(32'h200, 32'hB000_0200, 2'd2);
    @(negedge clock); rej_set = 1'b0; drive_st(32'h204, 32'hB000_0204, 2'd2);
    @(negedge clock); st_valid = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h300; ld_size = 2'd2; load_tag = 4'd3;
    wait_grant(n, got);
    check("t2_grant_same_cycle", n, 0);
    @(negedge clock); ld_req = 1'b0;
    ret_data(4'd3, 32'hDEADBEEF);
    #4; check("t2_pulse", {31'd0, ld_data_valid}, 32'd1);
    @(negedge clock); #4; check("t2_pulse_one_cycle", {31'd0, ld_data_valid}, 32'd0);
    wait_idle(ok);

    // 3: load to 0x402 blocked by buffered store to 0x400 until it drains.
    for (int k = 0; k < 3; k++) exp_bus(C_STORE, 2'd2, 32'h400, 32'hC000_0400, 1'b0);
    exp_bus(C_LOAD, 2'd1, 32'h402, 32'h0, 1'b1);
    ld_q.push_back(32'h0BADF00D);
    @(negedge clock); rej_cfg = 2; rej_set = 1'b1; drive_st(32'h400, 32'hC000_0400, 2'd2);
    @(negedge clock); rej_set = 1'b0; st_valid = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h402; ld_size = 2'd1; load_tag = 4'd7;
    wait_grant(n, got);
    check("t3_grant_after_store", n, 3);
    @(negedge clock); ld_req = 1'b0;
    ret_data(4'd7, 32'h0BADF00D);
    wait_idle(ok);

    // 4: squash in L_WAIT, late return dropped; then squash coinciding
    //    with the return.
    exp_bus(C_LOAD, 2'd2, 32'h500, 32'h0, 1'b1);
    exp_bus(C_LOAD, 2'd2, 32'h504, 32'h0, 1'b1);
    exp_bus(C_LOAD, 2'd2, 32'h508, 32'h0, 1'b1);
    ld_q.push_back(32'h600D600D);
    @(negedge clock); ld_req = 1'b1; ld_addr = 32'h500; ld_size = 2'd2; load_tag = 4'd5;
    wait_grant(n, got);
    check("t4_grant", {31'd0, got}, 32'd1);
    @(negedge clock); ld_req = 1'b0;
    @(negedge clock); ld_squash = 1'b1;
    @(negedge clock); ld_squash = 1'b0; #4;
    check("t4_drop_not_idle", {31'd0, idle}, 32'd0);
    @(negedge clock); mem_tag = 4'd5; mem_rdata = 32'hFFFF0000;
    @(negedge clock); mem_tag = 4'd0;
    ld_req = 1'b1; ld_addr = 32'h504; load_tag = 4'd6;
    wait_grant(n, got);
    check("t4_regrant_after_drop", n, 0);
    @(negedge clock); ld_req = 1'b0;
    ret_data(4'd6, 32'h600D600D);
    @(negedge clock); ld_req = 1'b1; ld_addr = 32'h508; load_tag = 4'd8;
    wait_grant(n, got);
    @(negedge clock); ld_req = 1'b0;
    @(negedge clock); ld_squash = 1'b1; mem_tag = 4'd8; mem_rdata = 32'h11112222;
    @(negedge clock); ld_squash = 1'b0; mem_tag = 4'd0; #4;
    check("t4_same_cycle_squash_idle", {31'd0, idle}, 32'd1);
    check("t4_same_cycle_no_pulse", {31'd0, ld_data_valid}, 32'd0);

    // 5: ten stores through a full buffer with push+pop, pointers wrap.
    for (int k = 0; k < 3; k++) exp_bus(C_STORE, 2'd0, 32'h600, 32'h5A5A_0000, 1'b0);
    for (int k = 0; k < 10; k++)
      exp_bus(C_STORE, 2'(k % 3), 32'h600 + 32'(4 * k), 32'h5A5A_0000 + 32'(k), 1'b0);
    saw_full = 1'b0;
    @(negedge clock); rej_cfg = 3; rej_set = 1'b1; drive_st(32'h600, 32'h5A5A_0000, 2'd0);
    i = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock); rej_set = 1'b0;
      if (st_full) begin
        saw_full = 1'b1; st_valid = 1'b0;
      end else if (i < 10) begin
        drive_st(32'h600 + 32'(4 * i), 32'h5A5A_0000 + 32'(i), 2'(i % 3));
        i++;
      end else begin
        st_valid = 1'b0; break;
      end
    end
    st_valid = 1'b0;
    check("t5_all_pushed", i, 10);
    check("t5_full_seen", {31'd0, saw_full}, 32'd1);
    wait_idle(ok);
    check("t5_idle_after_drain", {31'd0, ok}, 32'd1);

    // 6: async reset with stores buffered and a load in L_WAIT.
    exp_bus(C_LOAD, 2'd2, 32'h700, 32'h0, 1'b1);
    exp_bus(C_STORE, 2'd2, 32'h800, 32'hD000_0800, 1'b0);
    exp_bus(C_STORE, 2'd2, 32'h800, 32'hD000_0800, 1'b0);
    @(negedge clock); ld_req = 1'b1; ld_addr = 32'h700; ld_size = 2'd2; load_tag = 4'd9;
    wait_grant(n, got);
    @(negedge clock); ld_req = 1'b0; rej_cfg = 100; rej_set = 1'b1;
    drive_st(32'h800, 32'hD000_0800, 2'd2);
    @(negedge clock); rej_set = 1'b0; drive_st(32'h804, 32'hD000_0804, 2'd2);
    @(negedge clock); drive_st(32'h808, 32'hD000_0808, 2'd2); #4;
    check("t6_busy_before_reset", {31'd0, idle}, 32'd0);
    @(negedge clock); st_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("t6_rst_st_full", {31'd0, st_full}, 32'd0);
    check("t6_rst_idle", {31'd0, idle}, 32'd1);
    check("t6_rst_mem_command", {30'd0, mem_command}, 32'd0);
    check("t6_rst_ld_data_valid", {31'd0, ld_data_valid}, 32'd0);
    check("t6_rst_ld_data", ld_data, 32'd0);
    check("t6_rst_ld_grant", {31'd0, ld_grant}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1; rej_cfg = 0; rej_set = 1'b1;
    @(negedge clock); rej_set = 1'b0; mem_tag = 4'd9; mem_rdata = 32'hBAD0BAD0;
    @(negedge clock); mem_tag = 4'd0; #4;
    check("t6_stale_tag_no_pulse", {31'd0, ld_data_valid}, 32'd0);
    check("t6_idle_after_reset", {31'd0, idle}, 32'd1);
    @(negedge clock); @(negedge clock); #4;

    check("bus_queue_drained", bus_q.size(), 0);
    check("ld_queue_drained", ld_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
